// File: rtl/rysy_mem_pkg.sv
// Shared types and constants for the rysy memory-side responder.
package rysyMemPkg;

    // Default base of the MMIO window; addresses at or above it are MMIO.
    localparam logic [31:0] IO_BASE_DEFAULT = 32'h8000_0000;

    // MMIO register byte offsets from the window base.
    localparam logic [31:0] GPIO_OUT = 32'h0000_0000;
    localparam logic [31:0] GPIO_IN  = 32'h0000_0004;
    localparam logic [31:0] CYC_LO   = 32'h0000_0008;
    localparam logic [31:0] CYC_HI   = 32'h0000_000C;

    // Which source drives rdata for the access registered last cycle.
    typedef enum logic {REG_RAM, REG_IO} region_t;

endpackage

// File: rtl/rysy_mem_ram.sv
// Single-port, byte-enabled, read-first RAM with registered read data.
// Shaped so synthesis maps it onto block RAM (no reset on array or output).
module mem_ram #(
    parameter int AW        = 12,
    parameter     INIT_FILE = ""
) (
    input  logic          clk,
    input  logic [AW-1:0] idx,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [1<<AW];
    logic [31:0] rdata_q;

    // Per-lane write; the read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata_q <= mem[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/rysy_mem.sv
// Memory-side responder for the rysy core: on-chip RAM plus a small MMIO
// window (GPIO out/in, 64-bit cycle counter). One-cycle read latency, no stall.
module rysy_mem
    import rysyMemPkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter              INIT_FILE = "",
    parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic [31:0] gpio_o,
    input  logic [31:0] gpio_i
);

    localparam int AW = $clog2(MEM_WORDS);

    logic        is_io;
    logic [31:0] io_word;
    logic        wr_en;
    logic        ram_we;
    logic [31:0] ram_rdata;

    logic [31:0] gpio_q,      gpio_d;
    logic [63:0] cyc_q,       cyc_d;
    logic [31:0] snap_q,      snap_d;
    logic [31:0] sync1_q,     sync1_d;
    logic [31:0] sync2_q,     sync2_d;
    logic [31:0] io_rdata_q,  io_rdata_d;
    region_t     region_q,    region_d;

    // Address decode; writes are suppressed while reset is held.
    always_comb begin
        is_io   = (addr >= IO_BASE);
        io_word = (addr - IO_BASE) & ~32'h3;
        wr_en   = we & ~rst;
        ram_we  = wr_en & ~is_io;
    end

    mem_ram #(
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .idx   (addr[AW+1:2]),
        .we    (ram_we),
        .be    (be),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

    // MMIO next-state: GPIO write, counter, synchronizer, read mux, hi snapshot.
    always_comb begin
        gpio_d     = gpio_q;
        cyc_d      = cyc_q + 64'd1;
        snap_d     = snap_q;
        sync1_d    = gpio_i;
        sync2_d    = sync1_q;
        io_rdata_d = 32'h0;
        region_d   = is_io ? REG_IO : REG_RAM;

        if (wr_en && is_io && io_word == GPIO_OUT) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) gpio_d[8*i +: 8] = wdata[8*i +: 8];
            end
        end

        if (is_io) begin
            case (io_word)
                GPIO_OUT: io_rdata_d = gpio_q;
                GPIO_IN:  io_rdata_d = sync2_q;
                CYC_LO: begin
                    // Hi half frozen with the lo half returned, for a coherent 64-bit read.
                    io_rdata_d = cyc_q[31:0];
                    snap_d     = cyc_q[63:32];
                end
                CYC_HI:   io_rdata_d = snap_q;
                default:  io_rdata_d = 32'h0;
            endcase
        end
    end

    // State registers; reset steers the rdata mux to a zeroed MMIO path
    // because the RAM output register is deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_q     <= 32'h0;
            cyc_q      <= 64'h0;
            snap_q     <= 32'h0;
            sync1_q    <= 32'h0;
            sync2_q    <= 32'h0;
            io_rdata_q <= 32'h0;
            region_q   <= REG_IO;
        end else begin
            gpio_q     <= gpio_d;
            cyc_q      <= cyc_d;
            snap_q     <= snap_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            io_rdata_q <= io_rdata_d;
            region_q   <= region_d;
        end
    end

    assign rdata  = (region_q == REG_RAM) ? ram_rdata : io_rdata_q;
    assign gpio_o = gpio_q;

endmodule

// File: tb/tb_rysy_mem.sv
// Directed bench for rysy_mem: reset, RAM byte writes, read-first, aliasing,
// GPIO, synchronizer latency, coherent counter read, reset mid-write.
module tb_rysy_mem;

    localparam int          MEM_WORDS = 4096;
    localparam logic [31:0] IOB       = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic [31:0] gpio_o;
    logic [31:0] gpio_i;

    int n_cmp = 0;
    int n_bad = 0;

    rysy_mem #(
        .MEM_WORDS (MEM_WORDS),
        .INIT_FILE (""),
        .IO_BASE   (IOB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .be     (be),
        .rdata  (rdata),
        .gpio_o (gpio_o),
        .gpio_i (gpio_i)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        addr = a; we = 1'b0; be = 4'h0;
        step();
    endtask

    initial begin
        rst = 1'b1; addr = 32'h0; wdata = 32'h0; we = 1'b0; be = 4'h0; gpio_i = 32'h0;
        repeat (3) step();
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_gpio",  gpio_o, 32'h0);

        // First access after reset: counter was held at zero.
        rst = 1'b0;
        rd(IOB + 32'h8);
        chk("cyc_after_rst", rdata, 32'h0);

        // Full-word write then read back.
        wr(32'h10, 32'hDEAD_BEEF, 4'hF);
        rd(32'h10);
        chk("ram_full", rdata, 32'hDEAD_BEEF);

        // Single lane write.
        wr(32'h10, 32'h0000_AA00, 4'b0010);
        rd(32'h10);
        chk("ram_lane1", rdata, 32'hDEAD_AAEF);

        // Read-first: same-cycle write returns the old word.
        wr(32'h20, 32'h0, 4'hF);
        wr(32'h20, 32'h1111_1111, 4'hF);
        chk("read_first_old", rdata, 32'h0);
        rd(32'h20);
        chk("read_first_new", rdata, 32'h1111_1111);

        // Address aliasing modulo RAM size.
        rd(MEM_WORDS * 4 + 32'h10);
        chk("alias", rdata, 32'hDEAD_AAEF);

        // be=0 with we=1 changes nothing.
        wr(32'h10, 32'hFFFF_FFFF, 4'b0000);
        rd(32'h10);
        chk("be_zero", rdata, 32'hDEAD_AAEF);

        // GPIO out write and readback.
        wr(IOB, 32'h0000_00FF, 4'b0001);
        chk("gpio_o_ff", gpio_o, 32'h0000_00FF);
        wr(IOB, 32'h0000_AB00, 4'b0010);
        chk("gpio_o_lane1", gpio_o, 32'h0000_ABFF);
        rd(IOB);
        chk("gpio_rd", rdata, 32'h0000_ABFF);

        // Writing a read-only register has no effect on GPIO out.
        wr(IOB + 32'h4, 32'h1234_5678, 4'hF);
        chk("ro_write_ignored", gpio_o, 32'h0000_ABFF);

        // Synchronizer: new input value visible on the third read, not before.
        addr = IOB + 32'h4; gpio_i = 32'hA5A5_A5A5;
        step();
        step();
        chk("gpio_in_early", rdata, 32'h0);
        step();
        chk("gpio_in_sync", rdata, 32'hA5A5_A5A5);

        // Coherent 64-bit counter read across the 32-bit carry.
        addr = IOB + 32'h8;
        force dut.cyc_q = 64'h0000_0000_FFFF_FFFE;
        release dut.cyc_q;
        step();
        chk("cyc_lo_pre", rdata, 32'hFFFF_FFFE);
        rd(IOB + 32'hC);
        chk("cyc_hi_snap", rdata, 32'h0);
        rd(IOB + 32'h8);
        chk("cyc_lo_wrap", rdata, 32'h0);
        rd(IOB + 32'hC);
        chk("cyc_hi_carry", rdata, 32'h1);

        // Unmapped MMIO reads zero, writes ignored.
        wr(IOB + 32'h40, 32'hFFFF_FFFF, 4'hF);
        rd(IOB + 32'h40);
        chk("unmapped", rdata, 32'h0);

        // Reset during a RAM write: word is untouched, rdata zero, GPIO cleared.
        rst = 1'b1;
        wr(32'h10, 32'hCAFE_F00D, 4'hF);
        chk("rst_mid_rdata", rdata, 32'h0);
        chk("rst_mid_gpio", gpio_o, 32'h0);
        rst = 1'b0;
        rd(32'h10);
        chk("rst_mid_word", rdata, 32'hDEAD_AAEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
